// File: rtl/interface_channel_mux.sv
// N-channel merge: per-channel FIFO feeding a registered round-robin output stage; 2-cycle min latency.
// Backpressure: o_ready[k] drops when channel k is full; output holds while o_valid && !i_ready.

module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            push_vld,
  input  logic [Width-1:0] push_dat,
  output logic            push_rdy,
  input  logic            pop,
  output logic [Width-1:0] head_dat,
  output logic [CntW-1:0] count
);
  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Full is judged on current occupancy only, so a same-cycle pop never frees a slot early.
  assign push_rdy = (count < CntW'(Depth));
  assign push     = push_vld && push_rdy;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CntW'(1);
      else if (!push && pop) count <= count - CntW'(1);
    end
  end
endmodule

module interface_channel_mux #(
  parameter int NumCh = 4,
  parameter int Width = 8,
  parameter int Depth = 4,
  localparam int ChW  = (NumCh > 1) ? $clog2(NumCh) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NumCh-1:0]        i_valid,
  output logic [NumCh-1:0]        o_ready,
  input  logic [NumCh*Width-1:0]  i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [Width-1:0]        o_data,
  output logic [ChW-1:0]          o_ch,
  output logic [NumCh*CntW-1:0]   o_count
);
  logic [Width-1:0] head_dat [NumCh];
  logic [CntW-1:0]  cnt [NumCh];
  logic [NumCh-1:0] nonempty;
  logic [NumCh-1:0] pop;
  logic [ChW-1:0]   rr;
  logic [ChW-1:0]   gnt;
  logic             gnt_vld;
  logic             load_en;
  int               idx;

  assign load_en = !o_valid || i_ready;

  for (genvar k = 0; k < NumCh; k++) begin : g_ch
    sync_fifo #(.Width(Width), .Depth(Depth)) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .push_vld (i_valid[k]),
      .push_dat (i_data[k*Width +: Width]),
      .push_rdy (o_ready[k]),
      .pop      (pop[k]),
      .head_dat (head_dat[k]),
      .count    (cnt[k])
    );
    assign nonempty[k] = (cnt[k] != '0);
    assign pop[k]      = load_en && gnt_vld && (gnt == ChW'(k));
    assign o_count[k*CntW +: CntW] = cnt[k];
  end

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    gnt     = rr;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NumCh; i++) begin
      idx = (int'(rr) + i) % NumCh;
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = ChW'(idx);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      rr      <= ChW'(NumCh - 1);
    end else if (load_en) begin
      o_valid <= gnt_vld;
      if (gnt_vld) begin
        o_data <= head_dat[gnt];
        o_ch   <= gnt;
        rr     <= gnt;
      end
    end
  end
endmodule

// File: tb/tb_interface_channel_mux.sv
// Directed bench for interface_channel_mux at default parameters (4 ch, 8 bit, depth 4).
module tb_interface_channel_mux;
  localparam int NumCh = 4;
  localparam int Width = 8;
  localparam int CntW  = 3;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b0;
  logic [NumCh-1:0]       i_valid;
  logic [NumCh-1:0]       o_ready;
  logic [NumCh*Width-1:0] i_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [Width-1:0]       o_data;
  logic [1:0]             o_ch;
  logic [NumCh*CntW-1:0]  o_count;

  int total = 0;
  int bad   = 0;

  interface_channel_mux dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_ch    (o_ch),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic put(input int k, input logic [7:0] v);
    i_data[k*Width +: Width] = v;
  endtask

  function automatic logic [CntW-1:0] cnt_of(input int k);
    return o_count[k*CntW +: CntW];
  endfunction

  int nxt, rx, maxc;
  logic acc;

  initial begin
    i_valid = '0;
    i_data  = '0;
    i_ready = 1'b0;
    tick;
    tick;
    chk("rst_vld", o_valid, 0);
    chk("rst_dat", o_data, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_rdy", o_ready, 4'hF);
    chk("rst_cnt", o_count, 0);
    i_rst = 1'b1;

    // reset while beats are buffered and one sits in the output register
    put(0, 8'h01); put(1, 8'h02); i_valid = 4'b0011; tick;
    put(2, 8'h03); i_valid = 4'b0100; tick;
    i_valid = '0;
    chk("t1_pre_vld", o_valid, 1);
    chk("t1_pre_dat", o_data, 8'h01);
    #3 i_rst = 1'b0;
    #1;
    chk("t1_rst_vld", o_valid, 0);
    chk("t1_rst_dat", o_data, 0);
    chk("t1_rst_ch", o_ch, 0);
    chk("t1_rst_rdy", o_ready, 4'hF);
    chk("t1_rst_cnt", o_count, 0);
    #2 i_rst = 1'b1;
    tick;
    i_ready = 1'b1;
    put(0, 8'h44); put(1, 8'h33); i_valid = 4'b0011; tick;
    i_valid = '0;
    tick;
    chk("t1_first_vld", o_valid, 1);
    chk("t1_first_ch", o_ch, 0);
    chk("t1_first_dat", o_data, 8'h44);
    tick;
    chk("t1_second_ch", o_ch, 1);
    chk("t1_second_dat", o_data, 8'h33);
    tick;
    chk("t1_idle_vld", o_valid, 0);

    // single-beat latency
    put(2, 8'hA5); i_valid = 4'b0100; tick;
    i_valid = '0;
    chk("t2_e0_vld", o_valid, 0);
    tick;
    chk("t2_e1_vld", o_valid, 1);
    chk("t2_e1_dat", o_data, 8'hA5);
    chk("t2_e1_ch", o_ch, 2);
    tick;
    chk("t2_e2_vld", o_valid, 0);

    // fill channel 1 under back-pressure
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1, 8'(8'h10 + i)); i_valid = 4'b0010; tick;
    end
    i_valid = '0;
    chk("t3_out_dat", o_data, 8'h10);
    chk("t3_out_ch", o_ch, 1);
    chk("t3_cnt", cnt_of(1), 4);
    chk("t3_rdy_full", o_ready, 4'b1101);
    i_ready = 1'b1;
    tick;
    chk("t3_dat11", o_data, 8'h11);
    chk("t3_rdy_back", o_ready, 4'hF);
    for (int i = 2; i < 5; i++) begin
      tick;
      chk("t3_drain_dat", o_data, 8'h10 + i);
    end
    tick;
    chk("t3_drained_vld", o_valid, 0);

    // round-robin fairness from a fresh reset
    i_rst = 1'b0;
    i_ready = 1'b0;
    #1 i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NumCh; k++) put(k, 8'(k*16 + i));
      i_valid = 4'hF;
      tick;
    end
    i_valid = '0;
    chk("t4_hold_vld", o_valid, 1);
    chk("t4_hold_ch", o_ch, 0);
    chk("t4_hold_dat", o_data, 8'h00);
    chk("t4_cnt", o_count, {3'd3, 3'd3, 3'd3, 3'd2});
    i_ready = 1'b1;
    for (int j = 1; j < 12; j++) begin
      tick;
      chk("t4_rr_ch", o_ch, j % 4);
      chk("t4_rr_dat", o_data, (j % 4)*16 + j/4);
    end
    tick;
    chk("t4_end_vld", o_valid, 0);

    // streaming on channel 3 with toggling i_ready
    nxt = 0; rx = 0; maxc = 0;
    for (int cyc = 0; cyc < 200 && rx < 20; cyc++) begin
      i_ready = cyc[0];
      put(3, 8'(nxt));
      i_valid = (nxt < 20) ? 4'b1000 : 4'b0000;
      acc = i_valid[3] && o_ready[3];
      if (o_valid && i_ready) begin
        chk("t5_dat", o_data, rx);
        chk("t5_ch", o_ch, 3);
        rx++;
      end
      tick;
      if (acc) nxt++;
      if (int'(cnt_of(3)) > maxc) maxc = int'(cnt_of(3));
    end
    i_valid = '0;
    chk("t5_rx", rx, 20);
    chk("t5_tx", nxt, 20);
    chk("t5_maxcnt", maxc, 4);

    // stall stability while other channels fill
    i_ready = 1'b0;
    tick;
    put(2, 8'h77); i_valid = 4'b0100; tick;
    i_valid = '0;
    tick;
    chk("t6_vld", o_valid, 1);
    chk("t6_dat", o_data, 8'h77);
    for (int c = 0; c < 5; c++) begin
      put(0, 8'(8'h50 + c)); put(1, 8'(8'h60 + c)); i_valid = 4'b0011; tick;
      chk("t6_stall_vld", o_valid, 1);
      chk("t6_stall_dat", o_data, 8'h77);
      chk("t6_stall_ch", o_ch, 2);
      chk("t6_cnt0", cnt_of(0), (c + 1 > 4) ? 4 : c + 1);
      chk("t6_cnt1", cnt_of(1), (c + 1 > 4) ? 4 : c + 1);
    end
    i_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
